// File: rtl/key_cursor_ctrl.sv
// Keypad-driven cursor controller: key FIFO feeding an IDLE/FETCH/EXEC command FSM.
// Define CURSOR_WRAP_EN to make cursor motion wrap (x mod 16, y mod 12) instead of saturating.
module key_cursor_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       shift_mode,
  output logic       cell_we,
  output logic [3:0] cell_x,
  output logic [3:0] cell_y,
  output logic [3:0] cell_val,
  output logic       busy,
  output logic       ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [3:0] K_SHIFT  = 4'h0;
  localparam logic [3:0] K_ONE    = 4'h1;
  localparam logic [3:0] K_TWO    = 4'h2;
  localparam logic [3:0] K_THREE  = 4'h3;
  localparam logic [3:0] K_FIVE   = 4'h5;
  localparam logic [3:0] K_BUP    = 4'h6;
  localparam logic [3:0] K_BDOWN  = 4'h7;
  localparam logic [3:0] K_BLEFT  = 4'h8;
  localparam logic [3:0] K_BRIGHT = 4'h9;
  localparam logic [3:0] K_SPACE  = 4'hA;
  localparam logic [3:0] K_ENTER  = 4'hE;
  localparam logic [3:0] K_WAIT   = 4'hF;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t state, state_next;

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [3:0]    cmd;
  logic          empty, full, push_req, push, pop, exec;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign push_req = key_valid && (key_code != K_WAIT);
  // A full FIFO still accepts a key in the same cycle the FSM pops its head.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cmd   <= '0;
    end else begin
      state <= state_next;
      if (pop) cmd <= fifo_mem[rd_ptr];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop  = (state == FETCH);
    exec = (state == EXEC);
    busy = !empty || (state != IDLE);
  end

  // Six bits keep x+4 (up to 19) from overflowing before the range limit is applied.
  function automatic logic [3:0] limit(input logic signed [5:0] v, input logic signed [5:0] span);
    logic signed [5:0] r;
    r = v;
`ifdef CURSOR_WRAP_EN
    if (v < 6'sd0)        r = v + span;
    else if (v >= span)   r = v - span;
`else
    if (v < 6'sd0)        r = 6'sd0;
    else if (v >= span)   r = span - 6'sd1;
`endif
    return 4'(r);
  endfunction

  logic signed [5:0] step, x_s, y_s;

  always_comb begin
    step = shift_mode ? 6'sd4 : 6'sd1;
    x_s  = $signed({2'b00, cursor_x});
    y_s  = $signed({2'b00, cursor_y});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_x   <= '0;
      cursor_y   <= '0;
      shift_mode <= 1'b0;
      cell_we    <= 1'b0;
      cell_x     <= '0;
      cell_y     <= '0;
      cell_val   <= '0;
    end else begin
      cell_we <= 1'b0;
      if (exec) begin
        case (cmd)
          K_SHIFT:  shift_mode <= ~shift_mode;
          K_BUP:    cursor_y <= limit(y_s - step, 6'sd12);
          K_BDOWN:  cursor_y <= limit(y_s + step, 6'sd12);
          K_BLEFT:  cursor_x <= limit(x_s - step, 6'sd16);
          K_BRIGHT: cursor_x <= limit(x_s + step, 6'sd16);
          K_ONE, K_TWO, K_THREE, K_FIVE, K_SPACE: begin
            cell_we  <= 1'b1;
            cell_x   <= cursor_x;
            cell_y   <= cursor_y;
            cell_val <= (cmd == K_SPACE) ? 4'd0 : cmd;
          end
          K_ENTER: begin
            cursor_x   <= '0;
            cursor_y   <= '0;
            shift_mode <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Directed self-checking bench for key_cursor_ctrl; expectations follow CURSOR_WRAP_EN when defined.
module tb_key_cursor_ctrl;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] cursor_x, cursor_y, cell_x, cell_y, cell_val;
  logic       shift_mode, cell_we, busy, ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic [3:0] vals[$];

  key_cursor_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .shift_mode(shift_mode),
    .cell_we(cell_we), .cell_x(cell_x), .cell_y(cell_y), .cell_val(cell_val),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Record every write pulse on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cell_we === 1'b1) begin
      vals.push_back(cell_val);
      pulse_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after an edge; the key is sampled on the next rising edge.
  task automatic applyStimulus(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    applyStimulus(code);
    wait_edges(4);
  endtask

  task automatic check_reset_values(input string pfx);
    checkOutput({pfx, "_x"}, 32'(cursor_x), 0);
    checkOutput({pfx, "_y"}, 32'(cursor_y), 0);
    checkOutput({pfx, "_shift"}, 32'(shift_mode), 0);
    checkOutput({pfx, "_we"}, 32'(cell_we), 0);
    checkOutput({pfx, "_cx"}, 32'(cell_x), 0);
    checkOutput({pfx, "_cy"}, 32'(cell_y), 0);
    checkOutput({pfx, "_cval"}, 32'(cell_val), 0);
    checkOutput({pfx, "_busy"}, 32'(busy), 0);
    checkOutput({pfx, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    int p0;
    logic [3:0] burst [7];
    logic [3:0] burst_exp [6];
    burst     = '{4'h1, 4'h2, 4'h3, 4'h5, 4'hA, 4'h1, 4'h2};
    burst_exp = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd0, 4'd1};

    rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    #12;
    check_reset_values("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    // First BRIGHT doubles as a latency check: visible only after the third edge.
    applyStimulus(4'h9);
    wait_edges(2);
    checkOutput("lat_x_early", 32'(cursor_x), 0);
    checkOutput("lat_busy", 32'(busy), 1);
    wait_edges(1);
    checkOutput("lat_x", 32'(cursor_x), 1);
    checkOutput("lat_busy_done", 32'(busy), 0);
    wait_edges(1);
    press(4'h9); press(4'h9); press(4'h7);
    checkOutput("walk_x", 32'(cursor_x), 3);
    checkOutput("walk_y", 32'(cursor_y), 1);
    checkOutput("walk_busy", 32'(busy), 0);

    press(4'h9); press(4'h9);
    press(4'h0); press(4'h7); press(4'h0);
    press(4'h7); press(4'h7);
    checkOutput("pos_x", 32'(cursor_x), 5);
    checkOutput("pos_y", 32'(cursor_y), 7);
    checkOutput("pos_shift", 32'(shift_mode), 0);

    p0 = pulse_cnt;
    applyStimulus(4'h2);
    wait_edges(2);
    checkOutput("two_we_early", 32'(cell_we), 0);
    wait_edges(1);
    checkOutput("two_we", 32'(cell_we), 1);
    checkOutput("two_cx", 32'(cell_x), 5);
    checkOutput("two_cy", 32'(cell_y), 7);
    checkOutput("two_val", 32'(cell_val), 2);
    wait_edges(1);
    checkOutput("two_we_off", 32'(cell_we), 0);
    checkOutput("two_val_hold", 32'(cell_val), 2);
    checkOutput("two_cx_hold", 32'(cell_x), 5);
    checkOutput("two_cur_x", 32'(cursor_x), 5);
    checkOutput("two_cur_y", 32'(cursor_y), 7);
    checkOutput("two_pulses", 32'(pulse_cnt - p0), 1);

    press(4'h0);
    checkOutput("shift_on", 32'(shift_mode), 1);
    press(4'h7);
    checkOutput("y_to_11", 32'(cursor_y), 11);
    press(4'h7);
    checkOutput("y_high_edge", 32'(cursor_y), WRAP ? 3 : 11);
    press(4'h8);
    checkOutput("x_to_1", 32'(cursor_x), 1);
    press(4'h8);
    checkOutput("x_low_edge", 32'(cursor_x), WRAP ? 13 : 0);
    press(4'h9);
    checkOutput("x_back", 32'(cursor_x), WRAP ? 1 : 4);

    press(4'hE);
    checkOutput("enter_x", 32'(cursor_x), 0);
    checkOutput("enter_y", 32'(cursor_y), 0);
    checkOutput("enter_shift", 32'(shift_mode), 0);

    press(4'h0); press(4'h8);
    checkOutput("sl_shift", 32'(shift_mode), 1);
    checkOutput("sl_x", 32'(cursor_x), WRAP ? 12 : 0);
    press(4'h6);
    checkOutput("y_low_edge", 32'(cursor_y), WRAP ? 8 : 0);

    press(4'hE); press(4'h0);
    press(4'h9); press(4'h9); press(4'h9);
    checkOutput("x_to_12", 32'(cursor_x), 12);
    press(4'h9);
    checkOutput("x_high_edge", 32'(cursor_x), WRAP ? 0 : 15);
    press(4'hE);

    // WAIT never enters the queue; ADD is consumed silently.
    p0 = pulse_cnt;
    applyStimulus(4'hF);
    checkOutput("wait_busy0", 32'(busy), 0);
    wait_edges(1);
    checkOutput("wait_busy1", 32'(busy), 0);
    applyStimulus(4'hB);
    checkOutput("add_busy", 32'(busy), 1);
    wait_edges(4);
    checkOutput("add_x", 32'(cursor_x), 0);
    checkOutput("add_shift", 32'(shift_mode), 0);
    checkOutput("add_pulses", 32'(pulse_cnt - p0), 0);
    checkOutput("ovf_before", 32'(ovf), 0);

    // Seven back-to-back keys: two pops land inside the burst, so only the last is dropped.
    vals.delete();
    for (int i = 0; i < 7; i++) begin
      key_code  = burst[i];
      key_valid = 1'b1;
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    wait_edges(25);
    checkOutput("burst_ovf", 32'(ovf), 1);
    checkOutput("burst_count", 32'(vals.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < vals.size()) checkOutput($sformatf("burst_val%0d", i), 32'(vals[i]), 32'(burst_exp[i]));
    end
    checkOutput("burst_busy", 32'(busy), 0);

    press(4'h0); press(4'h9);
    checkOutput("pre_rst_x", 32'(cursor_x), 4);
    for (int i = 1; i <= 3; i++) begin
      key_code  = 4'(i);
      key_valid = 1'b1;
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    checkOutput("pre_rst_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    p0 = pulse_cnt;
    wait_edges(3);
    rst = 1'b1;
    wait_edges(10);
    checkOutput("post_rst_pulses", 32'(pulse_cnt - p0), 0);
    checkOutput("post_rst_busy", 32'(busy), 0);
    press(4'h9);
    checkOutput("resume_x", 32'(cursor_x), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
